multi_dma_wc_bst: RTL

//  Multi-channel burst DMA write engine: write-direction counterpart of the multi-channel burst read DMA.

---
 rtl/multi_dma_wc_bst.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_dma_wc_bst.sv
// ---------------------------------------------------------------------------
// multi_dma_wc_bst
//
// Multi-channel burst DMA write engine. Each channel collects an upstream
// valid/ready word stream in a private FIFO. Once a channel's FIFO holds a full
// burst (2**BL words) and the channel still has bursts left to transfer, it can
// be granted. The granted channel issues one burst write request to the bus
// interface unit and then streams 2**BL words. Channels are served round-robin.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   nch                   highest channel index that may be scheduled
//   pio_adr_we/len_we     per-channel register write strobes, data on pio_d
//   pio_d                 PIO write data (burst-aligned byte address / length)
//   pio_adr, pio_len      per-channel current byte address / remaining bytes
//   done                  pulse on the last accepted beat of a channel's final burst
//   err                   pulse after a PIO write hits a channel that is in a burst
//   dma_val/rdy/d         per-channel upstream word stream
//   biu_req/ack/adr/len   burst write request handshake
//   biu_wval/wrdy/wd      burst write data handshake
// ---------------------------------------------------------------------------
module multi_dma_wc_bst #(
    parameter int AL        = 2,
    parameter int AW        = 32,
    parameter int DW        = 8 * (2 ** AL),
    parameter int BL        = 4,
    parameter int FW        = 6,
    parameter int LW        = 24,
    parameter int CH        = 5,
    parameter int CW        = (CH > 1) ? $clog2(CH) : 1,
    parameter int BLEN_TYPE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CW-1:0]         nch,
    input  logic [CH-1:0]         pio_adr_we,
    input  logic [CH-1:0]         pio_len_we,
    input  logic [31:0]           pio_d,
    output logic [CH*32-1:0]      pio_adr,
    output logic [CH*32-1:0]      pio_len,
    output logic [CH-1:0]         done,
    output logic [CH-1:0]         err,
    input  logic [CH-1:0]         dma_val,
    output logic [CH-1:0]         dma_rdy,
    input  logic [CH*DW-1:0]      dma_d,
    output logic                  biu_req,
    input  logic                  biu_ack,
    output logic [AW-1:0]         biu_adr,
    output logic [BL-BLEN_TYPE:0] biu_len,
    output logic                  biu_wval,
    input  logic                  biu_wrdy,
    output logic [DW-1:0]         biu_wd
);

    localparam int SH    = BL + AL;      // byte offset bits inside one burst
    localparam int ARW   = AW - SH;      // address register width (burst units)
    localparam int LRW   = LW - SH;      // length register width (burst count)
    localparam int DEPTH = 2 ** FW;
    localparam int BURST = 2 ** BL;
    localparam int LENW  = BL - BLEN_TYPE + 1;
    localparam logic [LENW-1:0] BURST_LEN = LENW'((BLEN_TYPE != 0) ? BURST - 1 : BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA
    } state_t;

    // FSM state and registered bus outputs
    state_t          state_q;
    logic [CW-1:0]   sel_q;
    logic [CW-1:0]   ptr_q;
    logic [BL-1:0]   beat_q;
    logic            biu_req_q;
    logic            biu_wval_q;
    logic [CH-1:0]   err_q;

    // Per-channel PIO registers
    logic [ARW-1:0]  adr_q [CH];
    logic [LRW-1:0]  len_q [CH];

    // Per-channel FIFOs
    logic [DW-1:0]   mem_q    [CH][DEPTH];
    logic [FW-1:0]   wr_ptr_q [CH];
    logic [FW-1:0]   rd_ptr_q [CH];
    logic [FW:0]     cnt_q    [CH];
    logic [FW:0]     cnt_d    [CH];
    logic [CH-1:0]   full_q;

    logic [CH-1:0]   push;
    logic [CH-1:0]   pop;
    logic [CH-1:0]   active;
    logic [CH-1:0]   elig;
    logic            beat_fire;
    logic            last_beat;
    logic [CW-1:0]   scan_start;
    logic [CW-1:0]   pick;
    logic            found;
    logic [CW-1:0]   ptr_next;

    // Only the burst-aligned part of pio_d is stored.
    logic            unused_pio_lsb;
    assign unused_pio_lsb = ^pio_d[SH-1:0];

    assign beat_fire = (state_q == S_DATA) && biu_wrdy;
    assign last_beat = beat_fire && (beat_q == '1);
    assign ptr_next  = (sel_q >= nch) ? '0 : sel_q + CW'(1);

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        push   = '0;
        pop    = '0;
        active = '0;
        elig   = '0;
        done   = '0;
        for (int i = 0; i < CH; i++) begin
            push[i]   = dma_val[i] && !full_q[i];
            pop[i]    = beat_fire && (sel_q == CW'(i));
            active[i] = (state_q != S_IDLE) && (sel_q == CW'(i));
            elig[i]   = (CW'(i) <= nch) && (len_q[i] != '0)
                        && (cnt_q[i] >= (FW+1)'(BURST));
            done[i]   = last_beat && (sel_q == CW'(i)) && (len_q[i] == LRW'(1));
            cnt_d[i]  = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + (FW+1)'(1);
            end else if (pop[i] && !push[i]) begin
                cnt_d[i] = cnt_q[i] - (FW+1)'(1);
            end
        end
    end

    // Round-robin scan: first eligible channel at or above the start pointer,
    // otherwise the first eligible channel below it. Channels above nch are
    // never eligible, so this wraps at nch.
    always_comb begin
        scan_start = (ptr_q > nch) ? '0 : ptr_q;
        found      = 1'b0;
        pick       = '0;
        for (int i = 0; i < CH; i++) begin
            if (!found && elig[i] && (CW'(i) >= scan_start)) begin
                found = 1'b1;
                pick  = CW'(i);
            end
        end
        for (int i = 0; i < CH; i++) begin
            if (!found && elig[i]) begin
                found = 1'b1;
                pick  = CW'(i);
            end
        end
    end

    // Burst scheduler
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            ptr_q      <= '0;
            beat_q     <= '0;
            biu_req_q  <= 1'b0;
            biu_wval_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        sel_q     <= pick;
                        state_q   <= S_REQ;
                        biu_req_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (biu_ack) begin
                        state_q    <= S_DATA;
                        biu_req_q  <= 1'b0;
                        biu_wval_q <= 1'b1;
                        beat_q     <= '0;
                    end
                end
                S_DATA: begin
                    if (biu_wrdy) begin
                        beat_q <= beat_q + BL'(1);
                        if (beat_q == '1) begin
                            state_q    <= S_IDLE;
                            biu_wval_q <= 1'b0;
                            ptr_q      <= ptr_next;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // PIO registers. A channel in REQ/DATA refuses writes and flags err instead,
    // so the burst bookkeeping below never collides with a PIO write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                adr_q[i] <= '0;
                len_q[i] <= '0;
            end
            err_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                err_q[i] <= (pio_adr_we[i] || pio_len_we[i]) && active[i];
                if (pio_adr_we[i] && !active[i]) begin
                    adr_q[i] <= pio_d[AW-1:SH];
                end else if (last_beat && (sel_q == CW'(i))) begin
                    adr_q[i] <= adr_q[i] + ARW'(1);
                end
                if (pio_len_we[i] && !active[i]) begin
                    len_q[i] <= pio_d[LW-1:SH];
                end else if (last_beat && (sel_q == CW'(i))) begin
                    len_q[i] <= len_q[i] - LRW'(1);
                end
            end
        end
    end

    // FIFO pointers and occupancy. The full flag is registered, so a full FIFO
    // keeps dma_rdy low for the cycle in which it is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            full_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + FW'(1);
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + FW'(1);
                cnt_q[i]  <= cnt_d[i];
                full_q[i] <= (cnt_d[i] == (FW+1)'(DEPTH));
            end
        end
    end

    // NOTE: FIFO storage has no reset; emptiness is tracked by the pointers and
    // count, and stale words are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= dma_d[i*DW +: DW];
        end
    end

    assign dma_rdy  = ~full_q;
    assign err      = err_q;
    assign biu_req  = biu_req_q;
    assign biu_wval = biu_wval_q;
    assign biu_adr  = (state_q == S_REQ) ? {adr_q[sel_q], {SH{1'b0}}} : '0;
    assign biu_len  = (state_q == S_REQ) ? BURST_LEN : '0;
    assign biu_wd   = biu_wval_q ? mem_q[sel_q][rd_ptr_q[sel_q]] : '0;

    for (genvar g = 0; g < CH; g++) begin : g_pio_rd
        assign pio_adr[g*32 +: 32] = 32'({adr_q[g], {SH{1'b0}}});
        assign pio_len[g*32 +: 32] = 32'({len_q[g], {SH{1'b0}}});
    end

endmodule
